ofdm_subcarrier_mapper: RTL and testbench

- Downstream neighbour of the QAM modulator. Collects its serial constellation samples (QAM_EN / QAM_DATA_RE / QAM_DATA_IM, signed 1.15) into ping-pong buffers.
- Emits complete NFFT-point frequency-domain blocks for the IFFT, one sample per cycle. Each block carries the DC null, centred guard nulls, pilots and data in natural subcarrier order.

---
 rtl/ofdm_subcarrier_mapper_pkg.sv | 66 ++++++
 rtl/ofdm_pingpong_ram.sv | 80 ++++++++
 rtl/ofdm_subcarrier_mapper.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ofdm_subcarrier_mapper.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_subcarrier_mapper_pkg.sv
// Shared types, constants and subcarrier classification for the OFDM subcarrier mapper.
// Contents: sample width, default pilot amplitude, pilot-sign LFSR seed/taps,
// sample payload struct, subcarrier-type function and data-position counter.
package ofdm_subcarrier_mapper_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned LFSR_W   = 7;

   localparam logic signed [SAMPLE_W-1:0] PILOT_AMP_DEF = 16'sh5A82;

   // x^7 + x^4 + 1: feedback is the XOR of state bits 6 and 3
   localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b100_1000;

   typedef enum logic [1:0] {
      SC_NULL  = 2'd0,
      SC_PILOT = 2'd1,
      SC_DATA  = 2'd2
   } sc_type_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RUN  = 1'b1
   } rd_state_e;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } sample_t;

   // Classify subcarrier k: DC and centred guard band are nulls, then pilots on the grid
   function automatic sc_type_e sc_type(input int unsigned k,
                                        input int unsigned nfft,
                                        input int unsigned guard,
                                        input int unsigned spacing);
      sc_type_e t;
      if ((k == 0) || ((k >= nfft/2 - guard) && (k < nfft/2 + guard))) begin
         t = SC_NULL;
      end else if ((k % spacing) == 0) begin
         t = SC_PILOT;
      end else begin
         t = SC_DATA;
      end
      return t;
   endfunction

   // Number of data positions in one block
   function automatic int unsigned count_data(input int unsigned nfft,
                                              input int unsigned guard,
                                              input int unsigned spacing);
      int unsigned n;
      n = 0;
      for (int unsigned k = 0; k < nfft; k++) begin
         if (sc_type(k, nfft, guard, spacing) == SC_DATA) begin
            n++;
         end
      end
      return n;
   endfunction

   // One Fibonacci step; the MSB is the output (pilot sign) bit
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// Two-bank sample store for the subcarrier mapper.
// Ports: wr_* write one sample into a bank; set_* marks a bank full with a fill count;
// clr_* releases a drained bank; rd_bank/rd_addr feed a registered read port (rd_data);
// full/fill report per-bank status.
module ofdm_pingpong_ram
   import ofdm_subcarrier_mapper_pkg::*;
#(
   parameter int unsigned DEPTH = 45,
   parameter int unsigned AW    = 6
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 wr_bank,
   input  logic [AW-1:0]        wr_addr,
   input  sample_t              wr_data,
   input  logic                 set_en,
   input  logic                 set_bank,
   input  logic [AW-1:0]        set_fill,
   input  logic                 clr_en,
   input  logic                 clr_bank,
   input  logic                 rd_bank,
   input  logic [AW-1:0]        rd_addr,
   output sample_t              rd_data,
   output logic [1:0]           full,
   output logic [1:0][AW-1:0]   fill
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   sample_t             mem0 [DEPTH];
   sample_t             mem1 [DEPTH];
   sample_t             rd_data_q;
   logic [1:0]          full_q, full_d;
   logic [1:0][AW-1:0]  fill_q, fill_d;
   logic [AW-1:0]       rd_addr_c;
   logic [IDX_W-1:0]    wr_idx, rd_idx;

   // Past-the-end pointers read a harmless location; the reader masks them
   assign rd_addr_c = (rd_addr < AW'(DEPTH)) ? rd_addr : '0;
   assign rd_idx    = rd_addr_c[IDX_W-1:0];
   assign wr_idx    = wr_addr[IDX_W-1:0];

   // Storage: no reset, contents only matter below the fill count
   always_ff @(posedge clk) begin
      if (wr_en && !wr_bank) mem0[wr_idx] <= wr_data;
      if (wr_en &&  wr_bank) mem1[wr_idx] <= wr_data;
   end

   // Set and clear always target different banks, so both can land in one cycle
   always_comb begin
      full_d = full_q;
      fill_d = fill_q;
      for (int b = 0; b < 2; b++) begin
         if (set_en && (set_bank == 1'(b))) begin
            full_d[b] = 1'b1;
            fill_d[b] = set_fill;
         end else if (clr_en && (clr_bank == 1'(b))) begin
            full_d[b] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= '0;
         fill_q    <= '0;
         rd_data_q <= '0;
      end else begin
         full_q    <= full_d;
         fill_q    <= fill_d;
         rd_data_q <= rd_bank ? mem1[rd_idx] : mem0[rd_idx];
      end
   end

   assign rd_data = rd_data_q;
   assign full    = full_q;
   assign fill    = fill_q;

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// OFDM subcarrier mapper: buffers QAM samples in ping-pong banks and streams
// NFFT-point blocks (DC/guard nulls, pilots, data) to the IFFT one sample per cycle.
// Inputs: QAM_EN/QAM_DATA_RE/QAM_DATA_IM sample stream, FLUSH (close partial bank),
// OUT_READY (downstream backpressure). Outputs: MAP_EN/MAP_START/MAP_END/MAP_IDX/
// MAP_RE/MAP_IM block stream, OVF sticky overflow.
// Build option: define PILOT_PRBS_EN to take pilot signs from a 7-bit LFSR
// (x^7+x^4+1, seed 7'h7F, one step per transferred pilot); otherwise pilots are +PILOT_AMP.
module ofdm_subcarrier_mapper
   import ofdm_subcarrier_mapper_pkg::*;
#(
   parameter int unsigned                NFFT          = 64,
   parameter int unsigned                GUARD         = 6,
   parameter int unsigned                PILOT_SPACING = 8,
   parameter logic signed [SAMPLE_W-1:0] PILOT_AMP     = PILOT_AMP_DEF
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          QAM_EN,
   input  logic signed [SAMPLE_W-1:0]    QAM_DATA_RE,
   input  logic signed [SAMPLE_W-1:0]    QAM_DATA_IM,
   input  logic                          FLUSH,
   input  logic                          OUT_READY,
   output logic                          MAP_EN,
   output logic                          MAP_START,
   output logic                          MAP_END,
   output logic [$clog2(NFFT)-1:0]       MAP_IDX,
   output logic signed [SAMPLE_W-1:0]    MAP_RE,
   output logic signed [SAMPLE_W-1:0]    MAP_IM,
   output logic                          OVF
);

   localparam int unsigned IW     = $clog2(NFFT);
   localparam int unsigned N_DATA = count_data(NFFT, GUARD, PILOT_SPACING);
   localparam int unsigned AW     = $clog2(N_DATA + 1);

   // ---------------- shared buffer ----------------
   logic                 wr_en, set_en, clr_en;
   logic [AW-1:0]        set_fill, cnt_after;
   sample_t              wr_data, rd_data;
   logic [1:0]           full;
   logic [1:0][AW-1:0]   fill;

   logic                 wbank_q, wbank_d;
   logic [AW-1:0]        wcnt_q, wcnt_d;
   logic                 ovf_q, ovf_d;

   rd_state_e            state_q, state_d;
   logic [IW-1:0]        k_q, k_d;
   logic [AW-1:0]        dptr_q, dptr_d;
   logic                 rbank_q, rbank_d;
   logic                 done_q, done_d;
   logic                 map_en_q, map_en_d;
   logic                 map_start_q, map_start_d;
   logic                 map_end_q, map_end_d;
   logic [IW-1:0]        map_idx_q, map_idx_d;
   logic signed [SAMPLE_W-1:0] map_re_q, map_re_d;
   logic signed [SAMPLE_W-1:0] map_im_q, map_im_d;
   logic signed [SAMPLE_W-1:0] pilot_re;
   sc_type_e             sc_k;

   assign wr_data = '{re: QAM_DATA_RE, im: QAM_DATA_IM};

   ofdm_pingpong_ram #(
      .DEPTH (N_DATA),
      .AW    (AW)
   ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_bank  (wbank_q),
      .wr_addr  (wcnt_q),
      .wr_data  (wr_data),
      .set_en   (set_en),
      .set_bank (wbank_q),
      .set_fill (set_fill),
      .clr_en   (clr_en),
      .clr_bank (rbank_q),
      .rd_bank  (rbank_d),
      .rd_addr  (dptr_d),
      .rd_data  (rd_data),
      .full     (full),
      .fill     (fill)
   );

   // ---------------- write side ----------------
   // The write is resolved first; FLUSH then closes the bank only if it still holds samples
   always_comb begin
      wbank_d   = wbank_q;
      wcnt_d    = wcnt_q;
      ovf_d     = ovf_q;
      wr_en     = 1'b0;
      set_en    = 1'b0;
      set_fill  = '0;
      cnt_after = wcnt_q;
      if (QAM_EN) begin
         if (full[wbank_q]) begin
            ovf_d = 1'b1;
         end else begin
            wr_en     = 1'b1;
            cnt_after = wcnt_q + AW'(1);
         end
      end
      if (wr_en && (wcnt_q == AW'(N_DATA - 1))) begin
         set_en   = 1'b1;
         set_fill = AW'(N_DATA);
         wbank_d  = ~wbank_q;
         wcnt_d   = '0;
      end else if (FLUSH && (cnt_after != '0)) begin
         set_en   = 1'b1;
         set_fill = cnt_after;
         wbank_d  = ~wbank_q;
         wcnt_d   = '0;
      end else begin
         wcnt_d   = cnt_after;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank_q <= 1'b0;
         wcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbank_q <= wbank_d;
         wcnt_q  <= wcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // ---------------- pilot sign ----------------
`ifdef PILOT_PRBS_EN
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   // Step when the pilot currently on the output is consumed; a pilot loaded in the
   // same cycle already sees the stepped value
   always_comb begin
      lfsr_d = lfsr_q;
      if (map_en_q && OUT_READY &&
          (sc_type(32'(map_idx_q), NFFT, GUARD, PILOT_SPACING) == SC_PILOT)) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
      pilot_re = lfsr_d[LFSR_W-1] ? SAMPLE_W'(-PILOT_AMP) : PILOT_AMP;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign pilot_re = PILOT_AMP;
`endif

   // ---------------- read side ----------------
   assign sc_k = sc_type(32'(k_q), NFFT, GUARD, PILOT_SPACING);

   // rd_data always holds the buffered sample at (rbank_q, dptr_q): the RAM is addressed
   // with the next-state pointer one cycle ahead
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      dptr_d      = dptr_q;
      rbank_d     = rbank_q;
      done_d      = done_q;
      map_en_d    = map_en_q;
      map_start_d = map_start_q;
      map_end_d   = map_end_q;
      map_idx_d   = map_idx_q;
      map_re_d    = map_re_q;
      map_im_d    = map_im_q;
      clr_en      = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (full[rbank_q]) begin
               state_d = RD_RUN;
               k_d     = '0;
               dptr_d  = '0;
               done_d  = 1'b0;
            end
         end
         RD_RUN: begin
            if (done_q) begin
               // Last sample is on the output; release the bank once it is taken
               if (OUT_READY) begin
                  clr_en      = 1'b1;
                  rbank_d     = ~rbank_q;
                  dptr_d      = '0;
                  done_d      = 1'b0;
                  map_en_d    = 1'b0;
                  map_start_d = 1'b0;
                  map_end_d   = 1'b0;
                  map_idx_d   = '0;
                  map_re_d    = '0;
                  map_im_d    = '0;
                  if (full[~rbank_q]) begin
                     // k = 0 is always the DC null, so the next block starts with no gap
                     map_en_d    = 1'b1;
                     map_start_d = 1'b1;
                     k_d         = IW'(1);
                  end else begin
                     state_d = RD_IDLE;
                     k_d     = '0;
                  end
               end
            end else if (!map_en_q || OUT_READY) begin
               map_en_d    = 1'b1;
               map_idx_d   = k_q;
               map_start_d = (k_q == '0);
               map_end_d   = (k_q == IW'(NFFT - 1));
               map_re_d    = '0;
               map_im_d    = '0;
               case (sc_k)
                  SC_PILOT: map_re_d = pilot_re;
                  SC_DATA: begin
                     if (dptr_q < fill[rbank_q]) begin
                        map_re_d = rd_data.re;
                        map_im_d = rd_data.im;
                     end
                     dptr_d = dptr_q + AW'(1);
                  end
                  default: ;
               endcase
               if (k_q == IW'(NFFT - 1)) done_d = 1'b1;
               else                      k_d    = k_q + IW'(1);
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RD_IDLE;
         k_q         <= '0;
         dptr_q      <= '0;
         rbank_q     <= 1'b0;
         done_q      <= 1'b0;
         map_en_q    <= 1'b0;
         map_start_q <= 1'b0;
         map_end_q   <= 1'b0;
         map_idx_q   <= '0;
         map_re_q    <= '0;
         map_im_q    <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         dptr_q      <= dptr_d;
         rbank_q     <= rbank_d;
         done_q      <= done_d;
         map_en_q    <= map_en_d;
         map_start_q <= map_start_d;
         map_end_q   <= map_end_d;
         map_idx_q   <= map_idx_d;
         map_re_q    <= map_re_d;
         map_im_q    <= map_im_d;
      end
   end

   assign MAP_EN    = map_en_q;
   assign MAP_START = map_start_q;
   assign MAP_END   = map_end_q;
   assign MAP_IDX   = map_idx_q;
   assign MAP_RE    = map_re_q;
   assign MAP_IM    = map_im_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Self-checking bench for ofdm_subcarrier_mapper (default parameters, NFFT = 64).
module tb_ofdm_subcarrier_mapper;

   logic               clk = 1'b0;
   logic               rst, QAM_EN, FLUSH, OUT_READY;
   logic signed [15:0] QAM_DATA_RE, QAM_DATA_IM;
   logic               MAP_EN, MAP_START, MAP_END, OVF;
   logic [5:0]         MAP_IDX;
   logic signed [15:0] MAP_RE, MAP_IM;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   im_mode = 0;
   int   pilot_ord = 0;
   logic toggle_ready = 1'b0;

   typedef struct {
      logic [5:0]  idx;
      logic [15:0] re;
      logic [15:0] im;
      logic        st;
      logic        en;
      int          cyc;
   } rec_t;

   typedef struct {
      int          k;
      logic [15:0] re;
      logic [15:0] im;
      logic        st;
      logic        en;
   } vec_t;

   rec_t q[$];
   vec_t tbl[14];

   ofdm_subcarrier_mapper dut (
      .clk         (clk),
      .rst         (rst),
      .QAM_EN      (QAM_EN),
      .QAM_DATA_RE (QAM_DATA_RE),
      .QAM_DATA_IM (QAM_DATA_IM),
      .FLUSH       (FLUSH),
      .OUT_READY   (OUT_READY),
      .MAP_EN      (MAP_EN),
      .MAP_START   (MAP_START),
      .MAP_END     (MAP_END),
      .MAP_IDX     (MAP_IDX),
      .MAP_RE      (MAP_RE),
      .MAP_IM      (MAP_IM),
      .OVF         (OVF)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Alternating ready pattern when enabled
   initial forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) OUT_READY = ~OUT_READY;
   end

   // Transfer collector and stall-hold checker, sampled mid-cycle
   initial begin
      logic        prev_stall;
      logic [40:0] prev_vec, cur;
      prev_stall = 1'b0;
      prev_vec   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            cur = {MAP_EN, MAP_START, MAP_END, MAP_IDX, MAP_RE, MAP_IM};
            if (prev_stall) begin
               checks++;
               if (cur !== prev_vec) begin
                  errors++;
                  $display("FAIL hold at cycle %0d: got %h expected %h", cyc, cur, prev_vec);
               end
            end
            prev_stall = MAP_EN && !OUT_READY;
            prev_vec   = cur;
            if (MAP_EN && OUT_READY)
               q.push_back('{MAP_IDX, MAP_RE, MAP_IM, MAP_START, MAP_END, cyc});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] pilot_val(input int ord);
`ifdef PILOT_PRBS_EN
      logic [6:0] l;
      l = 7'h7F;
      for (int i = 0; i < ord; i++) l = {l[5:0], l[6] ^ l[3]};
      return l[6] ? 16'hA57E : 16'h5A82;
`else
      return (ord >= 0) ? 16'h5A82 : 16'h5A82;
`endif
   endfunction

   function automatic logic [15:0] s_re(input int n);
      return 16'(256 * n);
   endfunction

   function automatic logic [15:0] s_im(input int n);
      return (im_mode != 0) ? 16'(3 * n) : 16'(256 * n);
   endfunction

   task automatic do_reset();
      rst    = 1'b1;
      QAM_EN = 1'b0;
      FLUSH  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      q.delete();
      pilot_ord = 0;
   endtask

   task automatic send(input int n0, input int cnt);
      for (int i = 1; i <= cnt; i++) begin
         QAM_EN      = 1'b1;
         QAM_DATA_RE = s_re(n0 + i);
         QAM_DATA_IM = s_im(n0 + i);
         tick();
      end
      QAM_EN = 1'b0;
   endtask

   task automatic wait_xfers(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (q.size() < n && c < budget) begin
         tick();
         c++;
      end
      checks++;
      if (q.size() < n) begin
         errors++;
         $display("FAIL %s timeout: got %0d transfers expected %0d", name, q.size(), n);
      end
   endtask

   // Compare one captured block against the expected frame layout
   task automatic check_block(input string name, input int base, input int n0, input int fill);
      int j;
      logic [15:0] er, ei;
      j = 0;
      for (int k = 0; k < 64; k++) begin
         er = 16'h0;
         ei = 16'h0;
         if (k == 0 || (k >= 26 && k <= 37)) begin
            er = 16'h0;
         end else if (k % 8 == 0) begin
            er = pilot_val(pilot_ord);
            pilot_ord++;
         end else begin
            if (j < fill) begin
               er = s_re(n0 + j + 1);
               ei = s_im(n0 + j + 1);
            end
            j++;
         end
         if (base + k >= q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s k=%0d: got no transfer expected one", name, k);
         end else begin
            check($sformatf("%s k=%0d", name, k),
                  64'({q[base+k].idx, q[base+k].st, q[base+k].en, q[base+k].re, q[base+k].im}),
                  64'({6'(k), (k == 0), (k == 63), er, ei}));
         end
      end
   endtask

   initial begin
      tbl[0]  = '{0,  16'h0000, 16'h0000, 1'b1, 1'b0};
      tbl[1]  = '{26, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[2]  = '{37, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[3]  = '{8,  pilot_val(0), 16'h0000, 1'b0, 1'b0};
      tbl[4]  = '{16, pilot_val(1), 16'h0000, 1'b0, 1'b0};
      tbl[5]  = '{24, pilot_val(2), 16'h0000, 1'b0, 1'b0};
      tbl[6]  = '{40, pilot_val(3), 16'h0000, 1'b0, 1'b0};
      tbl[7]  = '{48, pilot_val(4), 16'h0000, 1'b0, 1'b0};
      tbl[8]  = '{56, pilot_val(5), 16'h0000, 1'b0, 1'b0};
      tbl[9]  = '{1,  16'h0100, 16'h0100, 1'b0, 1'b0};
      tbl[10] = '{63, 16'h2D00, 16'h2D00, 1'b0, 1'b1};
      tbl[11] = '{2,  16'h0200, 16'h0200, 1'b0, 1'b0};
      tbl[12] = '{25, 16'h1600, 16'h1600, 1'b0, 1'b0};
      tbl[13] = '{38, 16'h1700, 16'h1700, 1'b0, 1'b0};

      rst = 1'b1; QAM_EN = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
      QAM_DATA_RE = '0; QAM_DATA_IM = '0;
      tick();
      tick();
      check("reset_outputs",
            64'({MAP_EN, MAP_START, MAP_END, MAP_IDX, MAP_RE, MAP_IM, OVF}), 64'(0));
      rst = 1'b0;

      // Single block, latency and table of hand-computed samples
      im_mode = 0;
      OUT_READY = 1'b1;
      send(0, 45);
      check("latency_plus0", 64'(MAP_EN), 64'(0));
      tick();
      check("latency_plus1", 64'(MAP_EN), 64'(0));
      tick();
      check("latency_plus2", 64'({MAP_EN, MAP_START, MAP_IDX}), 64'({1'b1, 1'b1, 6'd0}));
      wait_xfers("blk1", 64, 200);
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].k < q.size())
            check($sformatf("table k=%0d", tbl[i].k),
                  64'({q[tbl[i].k].idx, q[tbl[i].k].re, q[tbl[i].k].im, q[tbl[i].k].st, q[tbl[i].k].en}),
                  64'({6'(tbl[i].k), tbl[i].re, tbl[i].im, tbl[i].st, tbl[i].en}));
      end
      check_block("blk1", 0, 0, 45);
      check("blk1_ovf", 64'(OVF), 64'(0));

      // Two back-to-back blocks
      do_reset();
      im_mode = 1;
      send(0, 90);
      wait_xfers("b2b", 128, 300);
      check_block("b2b_a", 0, 0, 45);
      check_block("b2b_b", 64, 45, 45);
      if (q.size() >= 128) check("b2b_span", 64'(q[127].cyc - q[0].cyc), 64'(127));
      check("b2b_ovf", 64'(OVF), 64'(0));

      // Overflow while the output is stalled
      do_reset();
      OUT_READY = 1'b0;
      send(0, 135);
      tick();
      check("ovf_set", 64'(OVF), 64'(1));
      check("ovf_no_xfer", 64'(q.size()), 64'(0));
      OUT_READY = 1'b1;
      wait_xfers("ovf", 128, 300);
      check_block("ovf_a", 0, 0, 45);
      check_block("ovf_b", 64, 45, 45);
      repeat (20) tick();
      check("ovf_count", 64'(q.size()), 64'(128));
      check("ovf_sticky", 64'(OVF), 64'(1));

      // FLUSH on an empty bank, then a partial bank
      do_reset();
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      repeat (10) tick();
      check("flush_empty", 64'({MAP_EN, 6'(q.size())}), 64'(0));
      send(0, 10);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      wait_xfers("flush", 64, 200);
      check_block("flush", 0, 0, 10);

      // FLUSH together with the 10th sample
      do_reset();
      send(0, 9);
      QAM_EN = 1'b1; QAM_DATA_RE = s_re(10); QAM_DATA_IM = s_im(10); FLUSH = 1'b1;
      tick();
      QAM_EN = 1'b0; FLUSH = 1'b0;
      wait_xfers("flush_same", 64, 200);
      check_block("flush_same", 0, 0, 10);

      // FLUSH with the completing sample is a no-op on the fresh bank
      do_reset();
      send(0, 44);
      QAM_EN = 1'b1; QAM_DATA_RE = s_re(45); QAM_DATA_IM = s_im(45); FLUSH = 1'b1;
      tick();
      QAM_EN = 1'b0; FLUSH = 1'b0;
      wait_xfers("flush_full", 64, 200);
      check_block("flush_full", 0, 0, 45);
      repeat (100) tick();
      check("flush_full_count", 64'(q.size()), 64'(64));

      // Alternating OUT_READY
      do_reset();
      OUT_READY = 1'b1;
      toggle_ready = 1'b1;
      send(0, 45);
      wait_xfers("toggle", 64, 400);
      toggle_ready = 1'b0;
      tick();
      OUT_READY = 1'b1;
      check_block("toggle", 0, 0, 45);
      if (q.size() >= 64) check("toggle_span", 64'(q[63].cyc - q[0].cyc), 64'(126));

      // Asynchronous reset in the middle of a block
      do_reset();
      OUT_READY = 1'b1;
      send(0, 45);
      wait_xfers("midrst", 20, 200);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_outputs", 64'({MAP_EN, MAP_START, MAP_END, MAP_IDX, MAP_RE, MAP_IM}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      pilot_ord = 0;
      repeat (5) tick();
      check("midrst_no_tail", 64'(q.size()), 64'(0));
      send(100, 45);
      wait_xfers("midrst_next", 64, 200);
      check_block("midrst_next", 0, 100, 45);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
